// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store initiator for a word-wide,
//            word-addressed data memory. Sub-word stores are done as
//            read-modify-write; loads return sign/zero-extended data.
//            Byte lanes are big-endian (offset 0 -> bits [31:24]).
// Options  : MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//            accesses skip memory and complete with err=1.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_RD_LAT = 1,   // read cycles before Read_data is sampled (1..15)
  parameter int ADDR_W     = 32   // CPU byte address / memory Address width
) (
  input  logic              clk,
  input  logic              rst,         // asynchronous, active-low
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       Write_data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [31:0]       Read_data
);

  // The read phase lasts MEM_RD_LAT cycles: load the counter with LAT-1 and
  // leave RD when it reaches zero.
  localparam logic [3:0] RD_CNT_INIT = 4'(MEM_RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;     // only sub-word stores need the data later
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_wr_q;
  logic              mem_rd_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W-1:0] addr_q;

  logic              misalign_d;
  logic              word_store_d;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_d;
  logic [31:0]       merge_d;

  assign word_store_d = we & size[1];

  // Flag misaligned requests at accept time; constant 0 when trapping is off
  always_comb begin
    misalign_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1) begin
      misalign_d = addr[0];
    end else if (size[1]) begin
      misalign_d = |addr[1:0];
    end
`endif
  end

  // Extract the addressed lane from the memory word and extend it for loads
  always_comb begin
    case (off_q)
      2'd0:    byte_v = Read_data[31:24];
      2'd1:    byte_v = Read_data[23:16];
      2'd2:    byte_v = Read_data[15:8];
      default: byte_v = Read_data[7:0];
    endcase
    half_v = off_q[1] ? Read_data[15:0] : Read_data[31:16];
    case (size_q)
      2'd0:    load_d = {{24{sext_q & byte_v[7]}}, byte_v};
      2'd1:    load_d = {{16{sext_q & half_v[15]}}, half_v};
      default: load_d = Read_data;
    endcase
  end

  // Replace only the target lane of the read word for sub-word stores
  always_comb begin
    merge_d = Read_data;
    if (size_q == 2'd0) begin
      case (off_q)
        2'd0:    merge_d[31:24] = wdata_q[7:0];
        2'd1:    merge_d[23:16] = wdata_q[7:0];
        2'd2:    merge_d[15:8]  = wdata_q[7:0];
        default: merge_d[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merge_d[15:0] = wdata_q;
    end else begin
      merge_d[31:16] = wdata_q;
    end
  end

  // Control FSM with all memory-side and CPU-side outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
      wdata_q   <= 16'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      rdata_q   <= 32'h0;
      wr_data_q <= 32'h0;
      addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            sext_q  <= sign_ext;
            size_q  <= size;
            off_q   <= addr[1:0];
            wdata_q <= wdata[15:0];
            addr_q  <= addr >> 2;
            busy_q  <= 1'b1;
            if (misalign_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (word_store_d) begin
              state_q   <= S_WR;
              mem_wr_q  <= 1'b1;
              wr_data_q <= wdata;
            end else begin
              state_q  <= S_RD;
              mem_rd_q <= 1'b1;
              cnt_q    <= RD_CNT_INIT;
            end
          end
        end
        S_RD: begin
          if (cnt_q == 4'd0) begin
            mem_rd_q <= 1'b0;
            if (we_q) begin
              state_q   <= S_WR;
              mem_wr_q  <= 1'b1;
              wr_data_q <= merge_d;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              rdata_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WR: begin
          mem_wr_q <= 1'b0;
          state_q  <= S_DONE;
          done_q   <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign Address    = addr_q;
  assign Write_data = wr_data_q;
  assign MemWrite   = mem_wr_q;
  assign MemRead    = mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized self-checking bench for load_store_unit. A
//            transaction-level model predicts, per cycle, busy/done/err,
//            the memory strobes, Address/Write_data and rdata, and keeps a
//            reference copy of memory. Directed cases pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int LAT = 3;
  localparam int AW  = 32;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'd0;
  logic          sign_ext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'h0;
  logic          busy, done, err, MemWrite, MemRead;
  logic [31:0]   rdata, Write_data, Read_data;
  logic [AW-1:0] Address;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_RD_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .Address(Address), .Write_data(Write_data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_data(Read_data)
  );

  // Data memory: 16 words, combinational read, write on the clock edge
  logic [31:0] mem_init [16];
  logic [31:0] mem      [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_init[i];
    end else if (MemWrite) begin
      mem[Address[3:0]] <= Write_data;
    end
  end
  assign Read_data = mem[Address[3:0]];

  // Inputs as the DUT saw them on each rising edge
  logic          smp_req = 1'b0, smp_we = 1'b0, smp_sext = 1'b0;
  logic [1:0]    smp_size = 2'd0;
  logic [AW-1:0] smp_addr = '0;
  logic [31:0]   smp_wdata = 32'h0;
  always @(posedge clk) begin
    smp_req   <= rst & req;
    smp_we    <= we;
    smp_size  <= size;
    smp_sext  <= sign_ext;
    smp_addr  <= addr;
    smp_wdata <= wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model + compare ----------------
  logic [31:0]   ref_mem [16];
  int            m_k = 0, m_lat = 0, m_rd = 0, m_wrk = 0, sh = 0;
  bit            prev_idle = 1'b1, prev_done = 1'b0;
  bit            m_mis = 1'b0, m_load = 1'b0, m_store = 1'b0;
  bit            e_act, e_mr, e_mw, e_done, e_err;
  logic [31:0]   m_rdata = 32'h0, m_res = 32'h0, m_wd = 32'h0, old, mask, v;
  logic [AW-1:0] m_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_k = 0; prev_idle = 1'b1; prev_done = 1'b0; m_rdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init[i];
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_address", Address, 0);
        chk("rst_write_data", Write_data, 0);
      end else begin
        if (prev_idle) begin
          if (smp_req) begin
            m_k    = 1;
            m_addr = smp_addr >> 2;
            m_mis  = TRAP && ((smp_size == 2'd1 && smp_addr[0]) ||
                              (smp_size >= 2'd2 && smp_addr[1:0] != 2'd0));
            old    = ref_mem[m_addr[3:0]];
            mask   = (smp_size == 2'd0) ? 32'hFF : (smp_size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            sh     = (smp_size == 2'd0) ? 8 * (3 - int'(smp_addr[1:0])) :
                     (smp_size == 2'd1) ? (smp_addr[1] ? 0 : 16) : 0;
            m_load = 1'b0; m_store = 1'b0; m_rd = 0; m_wrk = 0;
            if (m_mis) begin
              m_lat = 1;
            end else if (!smp_we) begin
              m_lat = LAT + 1; m_rd = LAT; m_load = 1'b1;
              v = (old >> sh) & mask;
              if (smp_sext && smp_size < 2'd2 && (v & ((mask + 32'd1) >> 1)) != 0) v = v | ~mask;
              m_res = v;
            end else if (smp_size >= 2'd2) begin
              m_lat = 2; m_wrk = 1; m_store = 1'b1; m_wd = smp_wdata;
            end else begin
              m_lat = LAT + 2; m_rd = LAT; m_wrk = LAT + 1; m_store = 1'b1;
              m_wd = (old & ~(mask << sh)) | ((smp_wdata & mask) << sh);
            end
          end
        end else begin
          m_k++;
          if (m_k > m_lat) m_k = 0;
        end
        e_act  = (m_k != 0);
        e_mr   = e_act && m_k <= m_rd;
        e_mw   = e_act && m_k == m_wrk;
        e_done = e_act && m_k == m_lat;
        e_err  = e_done && m_mis;
        if (e_done && m_load && !m_mis) m_rdata = m_res;
        if (e_done && m_store && !m_mis) ref_mem[m_addr[3:0]] = m_wd;
        chk("busy", busy, e_act);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("memread", MemRead, e_mr);
        chk("memwrite", MemWrite, e_mw);
        chk("rdata", rdata, m_rdata);
        if (e_mr || e_mw) chk("address", Address, m_addr);
        if (e_mw) chk("write_data", Write_data, m_wd);
        if (done) chk("done_adjacent", prev_done, 0);
        prev_done = done;
        prev_idle = !e_act;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        // Inputs are ignored while busy; scramble them to prove it
        req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3)); sign_ext = 1'($urandom_range(0, 1));
        addr = $urandom; wdata = $urandom;
      end
    end while (!done && lat < 40);
    req = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    rd = rdata;
    e  = err;
  endtask

  int          lat, n, nd;
  logic [31:0] rd, ra;
  logic        e;

  initial begin
    for (int i = 0; i < 16; i++) mem_init[i] = $urandom;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // sw 0x8 <- DEADBEEF
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, e);
    chk("sw_latency", lat, 2);
    chk("sw_mem", mem[2], 32'hDEADBEEF);

    // sb 0x9 <- AA into 11223344
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, lat, rd, e);
    issue(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AA, lat, rd, e);
    chk("sb_latency", lat, LAT + 2);
    chk("sb_mem", mem[2], 32'h11AA3344);

    // extension cases on 80FF7F01
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h80FF7F01, lat, rd, e);
    issue(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, lat, rd, e);
    chk("lb_latency", lat, LAT + 1);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, lat, rd, e);
    chk("lbu_rdata", rd, 32'h00000080);
    issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, lat, rd, e);
    chk("lh_low_rdata", rd, 32'h00007F01);
    issue(1'b0, 2'd1, 1'b1, 32'h8, 32'h0, lat, rd, e);
    chk("lh_high_rdata", rd, 32'hFFFF80FF);
    issue(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, lat, rd, e);
    chk("lhu_rdata", rd, 32'h000080FF);

    // req held high across two word loads
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h8;
    n = 0; nd = 0;
    while (nd < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) nd++;
    end
    req = 1'b0;
    chk("b2b_cycles", n, 2 * LAT + 3);

    // lw at misaligned 0x6
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, lat, rd, e);
    chk("lw_mis_latency", lat, TRAP ? 1 : LAT + 1);
    chk("lw_mis_err", e, TRAP ? 1 : 0);

    // word address truncation near the top of the address space
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFF8, 32'hCAFEF00D, lat, rd, e);
    chk("wrap_mem", mem[14], 32'hCAFEF00D);

    // reset during the read phase of an sb
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h9; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    chk("rst_mid_memread_before", MemRead, 1);
    #1 rst = 1'b0;
    #1 chk("rst_mid_memread_async", MemRead, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("rst_mid_busy_after", busy, 0);
    chk("rst_mid_mem_untouched", mem[2], mem_init[2]);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ra, $urandom, lat, rd, e);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
